ccg_sweep_ctrl: RTL and testbench

- Exhaustive-sweep test controller for the 5-input / 10-output combinational benchmark circuits in the dataset flow (e.g. an original netlist and its BALANCED rewrite).
- Drives every input vector 0..2^N_IN-1 into the DUT in order and compares the DUT response against a golden response.
- Counts mismatches, captures the first failing vector and compacts the DUT responses into a MISR signature.
- Sits in the equivalence/regression harness between the bench controller (start/abort) and the DUT plus golden model.

---
 rtl/ccg_sweep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ccg_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// ccg_sweep_ctrl
//
// Exhaustive-sweep controller for small combinational benchmark circuits.
// Steps `pattern` through every value 0 .. 2^N_IN-1, waits SETTLE extra
// cycles per vector, then samples the DUT response (`resp`) against the
// golden response (`ref_resp`). It counts mismatching vectors, records the
// first failing vector, and compacts every sampled response into a MISR
// signature.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   start            begin a sweep (accepted only while idle, abort low)
//   abort            terminate a sweep in progress
//   pattern          vector driven to the DUT and golden model
//   resp             DUT outputs
//   ref_resp         golden outputs
//   busy             high while a sweep is running
//   done             one-cycle pulse when a sweep completes normally
//   aborted          last sweep was aborted (cleared by the next start)
//   mismatch_cnt     number of sampled vectors with resp != ref_resp
//   first_fail_valid a first failing vector has been captured
//   first_fail_vec   pattern of the first failing vector
//   signature        MISR state
//
// All outputs come straight from flops; resp/ref_resp only feed next-state
// logic.
// ---------------------------------------------------------------------------
module ccg_sweep_ctrl #(
    parameter int              N_IN   = 5,
    parameter int              N_OUT  = 10,
    parameter int              SETTLE = 0,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   pattern,
    input  logic [N_OUT-1:0]  resp,
    input  logic [N_OUT-1:0]  ref_resp,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [N_IN:0]     mismatch_cnt,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic [SIG_W-1:0]  signature
);

    localparam int              CNT_W    = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [3:0]        wait_cnt, wait_n;
    logic [N_IN-1:0]   pattern_n;
    logic              busy_n;
    logic              done_n;
    logic              aborted_n;
    logic [CNT_W-1:0]  mcnt_n;
    logic              ffv_n;
    logic [N_IN-1:0]   ffvec_n;
    logic [SIG_W-1:0]  sig_n;
    logic              sample;

    // One MISR step: shift left, fold the MSB back through POLY, and XOR in
    // the zero-extended response word.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] s,
        input logic [N_OUT-1:0] d
    );
        logic [SIG_W-1:0] d_ext;
        logic [SIG_W-1:0] fb;
        d_ext            = '0;
        d_ext[N_OUT-1:0] = d;
        fb               = s[SIG_W-1] ? POLY : '0;
        return {s[SIG_W-2:0], 1'b0} ^ fb ^ d_ext;
    endfunction

    // Mismatch counter increment. It cannot wrap: at most 2^N_IN vectors
    // are sampled per sweep and the counter is N_IN+1 bits wide.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    // ---- next-state / next-output logic ----
    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        pattern_n = pattern;
        busy_n    = busy;
        done_n    = 1'b0;
        aborted_n = aborted;
        mcnt_n    = mismatch_cnt;
        ffv_n     = first_fail_valid;
        ffvec_n   = first_fail_vec;
        sig_n     = signature;
        sample    = 1'b0;

        case (state)
            IDLE: begin
                // A simultaneous abort cancels the start request.
                if (start && !abort) begin
                    state_n   = RUN;
                    wait_n    = '0;
                    pattern_n = '0;
                    busy_n    = 1'b1;
                    aborted_n = 1'b0;
                    mcnt_n    = '0;
                    ffv_n     = 1'b0;
                    ffvec_n   = '0;
                    sig_n     = SEED;
                end
            end

            RUN: begin
                if (abort) begin
                    // Partial results are kept; a coinciding sample is dropped.
                    state_n   = IDLE;
                    wait_n    = '0;
                    busy_n    = 1'b0;
                    aborted_n = 1'b1;
                end else if (wait_cnt == SETTLE_C) begin
                    sample = 1'b1;
                    if (pattern == LAST_VEC) begin
                        state_n = FIN;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        pattern_n = pattern + N_IN'(1);
                        wait_n    = '0;
                    end
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        if (sample) begin
            sig_n = misr_step(signature, resp);
            if (resp != ref_resp) begin
                mcnt_n = cnt_inc(mismatch_cnt);
                if (!first_fail_valid) begin
                    ffv_n   = 1'b1;
                    ffvec_n = pattern;
                end
            end
        end
    end

    // ---- state / result registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            pattern          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            signature        <= SEED;
        end else begin
            state            <= state_n;
            wait_cnt         <= wait_n;
            pattern          <= pattern_n;
            busy             <= busy_n;
            done             <= done_n;
            aborted          <= aborted_n;
            mismatch_cnt     <= mcnt_n;
            first_fail_valid <= ffv_n;
            first_fail_vec   <= ffvec_n;
            signature        <= sig_n;
        end
    end

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccg_sweep_ctrl
//
// Two controller instances: u0 (SETTLE=0) sweeps a small stand-in netlist
// with an optional two-vector fault injected into its golden copy; u2
// (SETTLE=2) sees an all-zero response against a golden that is non-zero
// whenever pattern[1:0]==2'b11 (8 of 32 vectors, first at vector 3).
// ---------------------------------------------------------------------------
module tb_ccg_sweep_ctrl;

    localparam logic [15:0] SEED_C = 16'hFFFF;
    localparam logic [15:0] POLY_C = 16'h1021;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, abort0, start2, abort2;
    logic        inj0;

    logic [4:0]  pat0, pat2;
    logic [9:0]  resp0, ref0, resp2, ref2;
    logic        busy0, done0, abt0, ffv0;
    logic        busy2, done2, abt2, ffv2;
    logic [5:0]  mc0, mc2;
    logic [4:0]  ffvec0, ffvec2;
    logic [15:0] sig0, sig2;

    logic [15:0] exp_sig1, exp_sig3, exp_sig4;

    int checks = 0;
    int errors = 0;

    // Stand-in for the benchmark netlist: 5 inputs, 10 outputs.
    function automatic logic [9:0] ccg_net(input logic [4:0] p);
        return {p[4] ^ p[0], p[3] & p[1], p[2] | p[4], ~p[0],
                p[1] ^ p[2] ^ p[3], p[4] & p[3], p[0] | p[2], p[1],
                p[3] ^ p[0], p[4] ^ p[2]};
    endfunction

    // Bit-serial reference MISR: x^16+x^12+x^5+1 with the response word
    // XORed into the low bits.
    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [9:0] d);
        logic [15:0] n;
        logic [15:0] dx;
        dx = {6'b0, d};
        for (int i = 0; i < 16; i++) begin
            n[i] = (s[15] & POLY_C[i]) ^ dx[i];
            if (i > 0) n[i] = n[i] ^ s[i-1];
        end
        return n;
    endfunction

    assign resp0 = ccg_net(pat0);
    assign ref0  = resp0 ^ ((inj0 && (pat0 == 5'h13 || pat0 == 5'h1A)) ? 10'h002 : 10'h000);
    assign resp2 = 10'h000;
    assign ref2  = (pat2[1:0] == 2'b11) ? 10'h155 : 10'h000;

    ccg_sweep_ctrl #(.N_IN(5), .N_OUT(10), .SETTLE(0), .SIG_W(16),
                     .POLY(16'h1021), .SEED(16'hFFFF)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .pattern(pat0), .resp(resp0), .ref_resp(ref0),
        .busy(busy0), .done(done0), .aborted(abt0), .mismatch_cnt(mc0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .signature(sig0)
    );

    ccg_sweep_ctrl #(.N_IN(5), .N_OUT(10), .SETTLE(2), .SIG_W(16),
                     .POLY(16'h1021), .SEED(16'hFFFF)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .pattern(pat2), .resp(resp2), .ref_resp(ref2),
        .busy(busy2), .done(done2), .aborted(abt2), .mismatch_cnt(mc2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .signature(sig2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; inj0 = 1'b0;

        exp_sig1 = SEED_C;
        for (int p = 0; p < 32; p++) exp_sig1 = misr_model(exp_sig1, ccg_net(5'(p)));
        exp_sig3 = SEED_C;
        for (int p = 0; p < 32; p++) exp_sig3 = misr_model(exp_sig3, 10'h000);
        exp_sig4 = SEED_C;
        for (int p = 0; p < 7; p++) exp_sig4 = misr_model(exp_sig4, 10'h000);

        repeat (3) tick;
        rst = 1'b0;

        // Reset state
        chk("rst_pat",   pat0, 0);
        chk("rst_busy",  busy0, 0);
        chk("rst_done",  done0, 0);
        chk("rst_abt",   abt0, 0);
        chk("rst_mc",    mc0, 0);
        chk("rst_ffv",   ffv0, 0);
        chk("rst_ffvec", ffvec0, 0);
        chk("rst_sig",   sig0, 16'hFFFF);
        chk("rst_busy2", busy2, 0);
        chk("rst_sig2",  sig2, 16'hFFFF);
        tick;

        // 1: SETTLE=0 clean sweep
        start0 = 1'b1; tick; start0 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            chk("t1_busy", busy0, 1);
            chk("t1_pat",  pat0, 32'(c - 1));
            chk("t1_done_low", done0, 0);
            tick;
        end
        chk("t1_done",  done0, 1);
        chk("t1_busy_end", busy0, 0);
        chk("t1_pat_hold", pat0, 31);
        chk("t1_mc",    mc0, 0);
        chk("t1_ffv",   ffv0, 0);
        chk("t1_sig",   sig0, exp_sig1);
        tick;
        chk("t1_done_pulse", done0, 0);
        chk("t1_idle_busy",  busy0, 0);

        // 2: two injected golden faults
        inj0 = 1'b1;
        start0 = 1'b1; tick; start0 = 1'b0;
        repeat (32) tick;
        chk("t2_done",  done0, 1);
        chk("t2_mc",    mc0, 2);
        chk("t2_ffv",   ffv0, 1);
        chk("t2_ffvec", ffvec0, 5'h13);
        chk("t2_sig",   sig0, exp_sig1);
        tick;

        // 6: start+abort together in IDLE
        start0 = 1'b1; abort0 = 1'b1; tick; start0 = 1'b0; abort0 = 1'b0;
        chk("t6_busy",  busy0, 0);
        chk("t6_abt",   abt0, 0);
        chk("t6_pat",   pat0, 31);
        chk("t6_mc",    mc0, 2);
        chk("t6_ffv",   ffv0, 1);
        chk("t6_ffvec", ffvec0, 5'h13);
        chk("t6_sig",   sig0, exp_sig1);
        tick;
        chk("t6_busy_later", busy0, 0);
        chk("t6_done", done0, 0);
        inj0 = 1'b0;

        // 3: SETTLE=2, resp forced to zero
        start2 = 1'b1; tick; start2 = 1'b0;
        for (int c = 1; c <= 96; c++) begin
            chk("t3_busy", busy2, 1);
            chk("t3_pat",  pat2, 32'((c - 1) / 3));
            tick;
        end
        chk("t3_done",  done2, 1);
        chk("t3_busy_end", busy2, 0);
        chk("t3_mc",    mc2, 8);
        chk("t3_ffv",   ffv2, 1);
        chk("t3_ffvec", ffvec2, 3);
        chk("t3_sig",   sig2, exp_sig3);
        tick;
        chk("t3_done_pulse", done2, 0);

        // 4: abort mid-wait at pattern 7
        start2 = 1'b1; tick; start2 = 1'b0;
        repeat (22) tick;
        chk("t4_pat_pre",  pat2, 7);
        chk("t4_busy_pre", busy2, 1);
        abort2 = 1'b1; tick; abort2 = 1'b0;
        chk("t4_busy",  busy2, 0);
        chk("t4_abt",   abt2, 1);
        chk("t4_done",  done2, 0);
        chk("t4_mc",    mc2, 1);
        chk("t4_ffv",   ffv2, 1);
        chk("t4_ffvec", ffvec2, 3);
        chk("t4_sig",   sig2, exp_sig4);
        chk("t4_pat",   pat2, 7);
        repeat (3) begin
            tick;
            chk("t4_no_done", done2, 0);
            chk("t4_idle",    busy2, 0);
            chk("t4_abt_hold", abt2, 1);
        end
        start2 = 1'b1; tick; start2 = 1'b0;
        chk("t4_restart_abt",  abt2, 0);
        chk("t4_restart_busy", busy2, 1);
        chk("t4_restart_pat",  pat2, 0);
        chk("t4_restart_mc",   mc2, 0);
        chk("t4_restart_ffv",  ffv2, 0);
        chk("t4_restart_sig",  sig2, SEED_C);

        // 5: start during RUN ignored, abort during FIN ignored, then rst mid-sweep
        start0 = 1'b1; tick; start0 = 1'b0;
        repeat (10) tick;
        chk("t5_pat10", pat0, 10);
        start0 = 1'b1; tick; start0 = 1'b0;
        chk("t5_pat11", pat0, 11);
        chk("t5_busy",  busy0, 1);
        repeat (21) tick;
        chk("t5_done",  done0, 1);
        chk("t5_pat",   pat0, 31);
        chk("t5_mc",    mc0, 0);
        chk("t5_sig",   sig0, exp_sig1);
        abort0 = 1'b1; tick; abort0 = 1'b0;
        chk("t5_fin_abt",  abt0, 0);
        chk("t5_fin_busy", busy0, 0);

        start0 = 1'b1; tick; start0 = 1'b0;
        repeat (20) tick;
        chk("t5_pat20", pat0, 20);
        rst = 1'b1; tick; rst = 1'b0;
        chk("t5r_pat",   pat0, 0);
        chk("t5r_busy",  busy0, 0);
        chk("t5r_done",  done0, 0);
        chk("t5r_abt",   abt0, 0);
        chk("t5r_mc",    mc0, 0);
        chk("t5r_ffv",   ffv0, 0);
        chk("t5r_ffvec", ffvec0, 0);
        chk("t5r_sig",   sig0, 16'hFFFF);
        chk("t5r_busy2", busy2, 0);
        chk("t5r_sig2",  sig2, 16'hFFFF);
        tick;
        chk("t5r_stay_idle", busy0, 0);
        chk("t5r_stay_pat",  pat0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
